// File: rtl/if_id.sv
// IF/ID pipeline register with RUN/HOLD/DRAIN control; all outputs registered (1-cycle latency), ifo_pc_next combinational.
// Stall holds the stage; build with IF_ID_DELAY_SLOT_EN to capture the delay-slot instruction instead of flushing it.
module if_id (
  input  logic        ifi_clk,
  input  logic        ifi_rst,
  input  logic        ifi_en,
  input  logic        ifi_stall,
  input  logic        ifi_flush,
  input  logic        ifi_interrupt,
  input  logic [15:0] ifi_pc,
  input  logic [15:0] ifi_instr,
  input  logic        ifi_ram2_oe,
  output logic [15:0] ifo_pc,
  output logic [15:0] ifo_pc_next,
  output logic [15:0] ifo_instr,
  output logic        ifo_valid,
  output logic [15:0] ifo_epc,
  output logic        ifo_draining,
  output logic [15:0] ifo_stall_cnt
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  drain_cnt, drain_cnt_nxt;
  logic [15:0] pc_nxt, instr_nxt, epc_nxt;
  logic        valid_nxt;
  logic        flush_act;

`ifdef IF_ID_DELAY_SLOT_EN
  // Delay-slot instruction survives a taken branch, so flush has no effect.
  assign flush_act = ifi_flush & 1'b0;
`else
  assign flush_act = ifi_flush;
`endif

  assign ifo_pc_next = ifo_pc + 16'd1;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pc_nxt        = ifo_pc;
    instr_nxt     = ifo_instr;
    valid_nxt     = ifo_valid;
    epc_nxt       = ifo_epc;
    if (state == DRAIN) begin
      // Interrupts are masked while draining; only a stall pauses the countdown.
      if (!ifi_stall) begin
        instr_nxt = NOP;
        valid_nxt = 1'b0;
        if (drain_cnt <= 2'd1) begin
          drain_cnt_nxt = 2'd0;
          state_nxt     = RUN;
        end else begin
          drain_cnt_nxt = drain_cnt - 2'd1;
        end
      end
    end else if (ifi_interrupt) begin
      epc_nxt       = ifo_valid ? ifo_pc : ifi_pc;
      instr_nxt     = NOP;
      valid_nxt     = 1'b0;
      drain_cnt_nxt = 2'd2;
      state_nxt     = DRAIN;
    end else if (flush_act) begin
      instr_nxt = NOP;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (ifi_stall) begin
      state_nxt = HOLD;
    end else if (!ifi_en) begin
      instr_nxt = NOP;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else begin
      pc_nxt    = ifi_pc;
      instr_nxt = ifi_ram2_oe ? NOP : ifi_instr;
      valid_nxt = ~ifi_ram2_oe;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge ifi_clk or negedge ifi_rst) begin
    if (!ifi_rst) begin
      state         <= RUN;
      drain_cnt     <= 2'd0;
      ifo_pc        <= 16'h0000;
      ifo_instr     <= NOP;
      ifo_valid     <= 1'b0;
      ifo_epc       <= 16'h0000;
      ifo_draining  <= 1'b0;
      ifo_stall_cnt <= 16'h0000;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      ifo_pc       <= pc_nxt;
      ifo_instr    <= instr_nxt;
      ifo_valid    <= valid_nxt;
      ifo_epc      <= epc_nxt;
      ifo_draining <= (state_nxt == DRAIN);
      if (ifi_stall && (ifo_stall_cnt != 16'hFFFF))
        ifo_stall_cnt <= ifo_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id.sv
// Bench for if_id: vector table through a scoreboard queue, then reset, wrap and saturation sequences.
module tb_if_id;

  logic        clk, rst, en, stall, flush, irq, oe;
  logic [15:0] pc, instr;
  logic [15:0] o_pc, o_pc_next, o_instr, o_epc, o_cnt;
  logic        o_valid, o_dr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en, stall, flush, irq, oe;
    logic [15:0] pc, instr;
    logic        chk_pc;
    logic [15:0] e_pc, e_instr;
    logic        e_valid, e_dr;
    logic [15:0] e_epc, e_cnt;
  } vec_t;

  vec_t vecs [16];
  vec_t sb [$];

  if_id dut (
    .ifi_clk(clk), .ifi_rst(rst), .ifi_en(en), .ifi_stall(stall), .ifi_flush(flush),
    .ifi_interrupt(irq), .ifi_pc(pc), .ifi_instr(instr), .ifi_ram2_oe(oe),
    .ifo_pc(o_pc), .ifo_pc_next(o_pc_next), .ifo_instr(o_instr), .ifo_valid(o_valid),
    .ifo_epc(o_epc), .ifo_draining(o_dr), .ifo_stall_cnt(o_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one vector, record its expectation, then score the DUT after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    en = v.en; stall = v.stall; flush = v.flush; irq = v.irq; oe = v.oe;
    pc = v.pc; instr = v.instr;
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (e.chk_pc) begin
      chk("pc", o_pc, e.e_pc);
      chk("pc_next", o_pc_next, e.e_pc + 16'd1);
    end
    chk("instr", o_instr, e.e_instr);
    chk("valid", {15'd0, o_valid}, {15'd0, e.e_valid});
    chk("draining", {15'd0, o_dr}, {15'd0, e.e_dr});
    chk("epc", o_epc, e.e_epc);
    chk("stall_cnt", o_cnt, e.e_cnt);
  endtask

  initial begin
    vec_t v;
    //          en    stall flush irq   oe    pc        instr     chk   e_pc      e_instr   e_v   e_dr  e_epc     e_cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h4A01, 1'b1, 16'h0010, 16'h4A01, 1'b1, 1'b0, 16'h0000, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h5B02, 1'b1, 16'h0011, 16'h0800, 1'b0, 1'b0, 16'h0000, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h1111, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b0, 16'h0000, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0013, 16'h6C03, 1'b1, 16'h0013, 16'h6C03, 1'b1, 1'b0, 16'h0000, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0014, 16'hAAAA, 1'b1, 16'h0013, 16'h6C03, 1'b1, 1'b0, 16'h0000, 16'd1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0015, 16'hBBBB, 1'b1, 16'h0013, 16'h6C03, 1'b1, 1'b0, 16'h0000, 16'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0016, 16'hCCCC, 1'b1, 16'h0013, 16'h6C03, 1'b1, 1'b0, 16'h0000, 16'd3};
`ifdef IF_ID_DELAY_SLOT_EN
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0014, 16'h1234, 1'b1, 16'h0014, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'd3};
`else
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0014, 16'h1234, 1'b1, 16'h0013, 16'h0800, 1'b0, 1'b0, 16'h0000, 16'd3};
`endif
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h7D04, 1'b1, 16'h0020, 16'h7D04, 1'b1, 1'b0, 16'h0000, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h8E05, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b1, 16'h0020, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0031, 16'h8E05, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b1, 16'h0020, 16'd3};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0032, 16'h9F06, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b0, 16'h0020, 16'd3};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033, 16'hA007, 1'b1, 16'h0033, 16'hA007, 1'b1, 1'b0, 16'h0020, 16'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0034, 16'hB008, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b1, 16'h0033, 16'd3};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0035, 16'hC009, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b1, 16'h0033, 16'd4};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0036, 16'hC00A, 1'b0, 16'h0000, 16'h0800, 1'b0, 1'b1, 16'h0033, 16'd5};

    rst = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0; irq = 1'b0; oe = 1'b0;
    pc = 16'h0000; instr = 16'h0000;
    #12;
    chk("rst_pc", o_pc, 16'h0000);
    chk("rst_pc_next", o_pc_next, 16'h0001);
    chk("rst_instr", o_instr, 16'h0800);
    chk("rst_valid", {15'd0, o_valid}, 16'h0000);
    chk("rst_epc", o_epc, 16'h0000);
    chk("rst_draining", {15'd0, o_dr}, 16'h0000);
    chk("rst_cnt", o_cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) step(vecs[i]);

    // Now in DRAIN with five stall cycles counted: reset asynchronously mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_instr", o_instr, 16'h0800);
    chk("arst_valid", {15'd0, o_valid}, 16'h0000);
    chk("arst_draining", {15'd0, o_dr}, 16'h0000);
    chk("arst_cnt", o_cnt, 16'h0000);
    chk("arst_epc", o_epc, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'hB008, 1'b1, 16'h0040, 16'hB008, 1'b1, 1'b0, 16'h0000, 16'd0};
    step(v);
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hC009, 1'b1, 16'hFFFF, 16'hC009, 1'b1, 1'b0, 16'h0000, 16'd0};
    step(v);
    chk("wrap_pc_next", o_pc_next, 16'h0000);

    stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_near_sat", o_cnt, 16'hFFFE);
    @(posedge clk); #1;
    chk("cnt_sat", o_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("cnt_hold_sat", o_cnt, 16'hFFFF);
    chk("hold_pc", o_pc, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 SHALL have ifi_clk  input  1  stage clock; all state updates on rising edge.
REQ-002 SHALL have ifi_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ifi_en  input  1  global pipeline enable; 0 loads bubble.
REQ-004 SHALL have ifi_stall  input  1  hazard hold request from hazard unit.
REQ-005 SHALL have ifi_flush  input  1  taken branch resolved downstream; kill incoming instruction.
REQ-006 SHALL have ifi_interrupt  input  1  interrupt request, single-cycle pulse.
REQ-007 SHALL have ifi_pc  input  16  fetch address from PC stage.
REQ-008 SHALL have ifi_instr  input  16  fetched instruction word from instruction RAM.
REQ-009 SHALL have ifi_ram2_oe  input  1  instruction RAM output enable; 0 = ifi_instr valid this cycle.
REQ-010 SHALL have ifo_pc  output  16  PC of instruction held in ID.
REQ-011 SHALL have ifo_pc_next  output  16  ifo_pc + 1, modulo 2^16.
REQ-012 SHALL have ifo_instr  output  16  instruction presented to decode.
REQ-013 SHALL have ifo_valid  output  1  ifo_instr is a real instruction, not a bubble.
REQ-014 SHALL have ifo_epc  output  16  captured exception return address.
REQ-015 SHALL have ifo_draining  output  1  high while in DRAIN state.
REQ-016 SHALL have ifo_stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 SHALL implement states RUN, HOLD, DRAIN; bubble = ifo_instr 16'h0800 (NOP), ifo_valid 0.
REQ-018 SHALL evaluate per edge in priority: interrupt > flush > stall > ~ifi_en > capture.
REQ-019 SHALL, in RUN/HOLD on ifi_interrupt, set ifo_epc = ifo_valid ? ifo_pc : ifi_pc, load bubble, enter DRAIN with drain count 2.
REQ-020 SHALL, in DRAIN, load bubble each unstalled cycle, decrement count, return to RUN after the 2nd bubble; ifi_stall freezes count; ifi_interrupt ignored (ifo_epc unchanged).
REQ-021 SHALL, on ifi_flush (no interrupt), load bubble and leave ifo_pc unchanged.
REQ-022 SHALL, on ifi_stall (no interrupt/flush), hold ifo_pc, ifo_instr, ifo_valid and enter/stay HOLD; leave HOLD on first cycle stall is low.
REQ-023 SHALL, on ifi_en=0, load bubble regardless of ifi_ram2_oe.
REQ-024 SHALL, on capture, load ifo_pc=ifi_pc, ifo_instr=ifi_instr, ifo_valid=1 when ifi_ram2_oe=0, else bubble with ifo_pc=ifi_pc.
REQ-025 SHALL increment ifo_stall_cnt each edge with ifi_stall=1 in any state, saturating at 16'hFFFF.
REQ-026 SHALL provide all outputs directly from registers (one-cycle latency input to output), except ifo_pc_next derived combinationally from ifo_pc.

Reset
REQ-027 SHALL, while ifi_rst=0, force state RUN, ifo_pc 0, ifo_instr 16'h0800, ifo_valid 0, ifo_epc 0, drain count 0, ifo_stall_cnt 0, independent of clock.
REQ-028 SHALL abandon any DRAIN or HOLD in progress on reset; first post-reset edge behaves as RUN.

Configuration
REQ-029 SHALL recognise macro IF_ID_DELAY_SLOT_EN.
REQ-030 SHALL, with IF_ID_DELAY_SLOT_EN defined, ignore ifi_flush (delay-slot instruction captured normally).
REQ-031 SHALL, without IF_ID_DELAY_SLOT_EN, apply REQ-021.

Verification
REQ-032 SHALL test capture: ifi_pc=16'h0010, ifi_instr=16'h4A01, oe=0 -> next edge ifo_pc=0010, ifo_instr=4A01, ifo_valid=1, ifo_pc_next=0011.
REQ-033 SHALL test stall: 3 cycles ifi_stall=1 with changing ifi_instr -> outputs frozen, ifo_stall_cnt=3.
REQ-034 SHALL test flush: ifi_flush=1 with ifi_instr=16'h1234 -> ifo_instr=0800, ifo_valid=0 (macro undefined); ifo_instr=1234, ifo_valid=1 (macro defined).
REQ-035 SHALL test interrupt: ifo_valid=1, ifo_pc=16'h0020, pulse ifi_interrupt -> ifo_epc=0020, two bubbles with ifo_draining=1, then capture resumes; second pulse in DRAIN leaves ifo_epc=0020.
REQ-036 SHALL test reset in DRAIN with ifo_stall_cnt=5: ifi_rst=0 mid-cycle -> immediately ifo_instr=0800, ifo_valid=0, ifo_draining=0, ifo_stall_cnt=0.
REQ-037 SHALL test boundaries: ifo_pc=16'hFFFF gives ifo_pc_next=0000; ifo_stall_cnt preset near FFFF saturates at FFFF.
